// File: rtl/qpsk_pkg.sv
// QPSK demodulator shared constants and state encoding.
// Frame: 11 symbols x 40 samples, 2 bits per symbol plus one pad bit.
package qpsk_pkg;

  localparam int SAMPLES_PER_SYM = 40;
  localparam int SYMS_PER_FRAME  = 11;
  localparam int DATA_W          = 21;
  localparam int SHREG_W         = 2 * SYMS_PER_FRAME;
  localparam logic [15:0] MIDSCALE = 16'd32768;

  typedef enum logic [1:0] {
    ACC,
    DECIDE,
    OUT
  } demod_state_e;

endpackage

// File: rtl/qpsk_demod_if.sv
// Sample-in / word-out handshake bundle of the QPSK demodulator.
// slave is the demodulator view, master the source/host view.
interface qpsk_demod_if;
  import qpsk_pkg::*;

  logic [15:0]       indata;
  logic              inwrite;
  logic              waitwrite;
  logic              frame_end;
  logic [DATA_W-1:0] outdata;
  logic              outvalid;
  logic              outack;
  logic              sync_err;

  modport slave (
    input  indata, inwrite, frame_end, outack,
    output waitwrite, outdata, outvalid, sync_err
  );

  modport master (
    output indata, inwrite, frame_end, outack,
    input  waitwrite, outdata, outvalid, sync_err
  );

endinterface

// File: rtl/qpsk_ref_lut.sv
// Reference carrier table: cos/sin of 9 deg * index, index 0..39.
// sin[n] is read as cos[(n+30) mod 40], so one table serves both.
module qpsk_ref_lut #(
  parameter int COEF_W = 16
) (
  input  logic [5:0]               index,
  output logic signed [COEF_W-1:0] cos_c,
  output logic signed [COEF_W-1:0] sin_c
);

  // round(32767 * cos(9 deg * k))
  function automatic logic signed [15:0] cos_tab(
    input logic [5:0] k
  );
    case (k)
      6'd0:  return  16'sd32767;
      6'd1:  return  16'sd32364;
      6'd2:  return  16'sd31163;
      6'd3:  return  16'sd29196;
      6'd4:  return  16'sd26509;
      6'd5:  return  16'sd23170;
      6'd6:  return  16'sd19260;
      6'd7:  return  16'sd14876;
      6'd8:  return  16'sd10126;
      6'd9:  return  16'sd5126;
      6'd10: return  16'sd0;
      6'd11: return -16'sd5126;
      6'd12: return -16'sd10126;
      6'd13: return -16'sd14876;
      6'd14: return -16'sd19260;
      6'd15: return -16'sd23170;
      6'd16: return -16'sd26509;
      6'd17: return -16'sd29196;
      6'd18: return -16'sd31163;
      6'd19: return -16'sd32364;
      6'd20: return -16'sd32767;
      6'd21: return -16'sd32364;
      6'd22: return -16'sd31163;
      6'd23: return -16'sd29196;
      6'd24: return -16'sd26509;
      6'd25: return -16'sd23170;
      6'd26: return -16'sd19260;
      6'd27: return -16'sd14876;
      6'd28: return -16'sd10126;
      6'd29: return -16'sd5126;
      6'd30: return  16'sd0;
      6'd31: return  16'sd5126;
      6'd32: return  16'sd10126;
      6'd33: return  16'sd14876;
      6'd34: return  16'sd19260;
      6'd35: return  16'sd23170;
      6'd36: return  16'sd26509;
      6'd37: return  16'sd29196;
      6'd38: return  16'sd31163;
      6'd39: return  16'sd32364;
      default: return 16'sd0;
    endcase
  endfunction

  logic [5:0] sidx;

  always_comb begin
    sidx  = (index >= 6'd10) ? index - 6'd10
                             : index + 6'd30;
    cos_c = COEF_W'(cos_tab(index));
    sin_c = COEF_W'(cos_tab(sidx));
  end

endmodule

// File: rtl/qpsk_demod.sv
// QPSK demodulator: per-symbol I/Q correlation, quadrant slicer,
// 21-bit word rebuild held on a valid/ack output.
module qpsk_demod
  import qpsk_pkg::*;
#(
  parameter int COEF_W = 16,
  parameter int ACC_W  = 17 + COEF_W + 6
) (
  input logic         clk,
  input logic         reset,
  qpsk_demod_if.slave bus
);

  localparam int PW = 17 + COEF_W;

  demod_state_e state, state_nx;

  logic [5:0]               sample_cnt;
  logic [3:0]               sym_cnt;
  logic signed [ACC_W-1:0]  acc_i, acc_q;
  logic [SHREG_W-1:0]       shreg;
  logic [DATA_W-1:0]        outdata_q;
  logic                     sync_err_q;

  logic signed [COEF_W-1:0] cos_c, sin_c;
  logic signed [16:0]       x;
  logic signed [PW-1:0]     prod_i, prod_q;
  logic signed [ACC_W-1:0]  ext_i, ext_q;
  logic accept, started, resync, overrun;
  logic last_smp, last_sym, b1, b0;

  qpsk_ref_lut #(.COEF_W(COEF_W)) u_lut (
    .index (sample_cnt),
    .cos_c (cos_c),
    .sin_c (sin_c)
  );

  always_comb begin
    x = $signed({1'b0, bus.indata}
              - {1'b0, MIDSCALE});
    prod_i = PW'(x) * PW'(cos_c);
    prod_q = PW'(x) * PW'(sin_c);
    ext_i  = ACC_W'(prod_i);
    ext_q  = ACC_W'(prod_q);
    accept = bus.inwrite && (state != OUT);
    // any sample of the current frame seen, including this cycle's
    started = accept || (state == DECIDE)
           || (sample_cnt != '0) || (sym_cnt != '0);
    resync  = bus.frame_end && (state != OUT)
           && started;
    overrun  = bus.inwrite && (state == OUT);
    last_smp = sample_cnt == 6'(SAMPLES_PER_SYM - 1);
    last_sym = sym_cnt == 4'(SYMS_PER_FRAME - 1);
    b1 = acc_i[ACC_W-1];
    b0 = acc_i[ACC_W-1] ^ acc_q[ACC_W-1];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ACC;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACC: begin
        if (resync)
          state_nx = ACC;
        else if (accept && last_smp)
          state_nx = DECIDE;
      end
      DECIDE: begin
        if (resync)        state_nx = ACC;
        else if (last_sym) state_nx = OUT;
        else               state_nx = ACC;
      end
      OUT: begin
        if (bus.outack) state_nx = ACC;
      end
      default: state_nx = ACC;
    endcase
  end

  always_comb begin
    bus.outvalid  = (state == OUT);
    bus.waitwrite = (state != OUT);
    bus.outdata   = outdata_q;
    bus.sync_err  = sync_err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_i      <= '0;
      acc_q      <= '0;
      sample_cnt <= '0;
      sym_cnt    <= '0;
      shreg      <= '0;
      outdata_q  <= '0;
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= resync | overrun;
      if (resync) begin
        acc_i      <= '0;
        acc_q      <= '0;
        sample_cnt <= '0;
        sym_cnt    <= '0;
        shreg      <= '0;
      end else begin
        unique case (state)
          ACC: begin
            if (accept) begin
              acc_i      <= acc_i + ext_i;
              acc_q      <= acc_q + ext_q;
              sample_cnt <= last_smp ? 6'd0
                                     : sample_cnt + 6'd1;
            end
          end
          DECIDE: begin
            shreg   <= {shreg[SHREG_W-3:0], b1, b0};
            sym_cnt <= sym_cnt + 4'd1;
            // a sample arriving now opens the next symbol
            acc_i      <= accept ? ext_i : '0;
            acc_q      <= accept ? ext_q : '0;
            sample_cnt <= accept ? 6'd1 : 6'd0;
            if (last_sym)
              outdata_q <= {shreg[SHREG_W-3:0], b1};
          end
          OUT: begin
            if (bus.outack) sym_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qpsk_demod.sv
// Self-checking bench for qpsk_demod: table frames, resync,
// hold/overrun corner cases and noisy random frames vs a real model.
module tb_qpsk_demod;
  import qpsk_pkg::*;

  localparam int FR = SAMPLES_PER_SYM * SYMS_PER_FRAME;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qpsk_demod_if bif();

  qpsk_demod dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  typedef struct {
    logic [20:0] word;
    int          gmax;
    int          hold;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[4];
  int   fr[FR];
  int   checks = 0;
  int   errors = 0;
  int   sync_cnt = 0;

  always @(negedge clk)
    if (bif.sync_err === 1'b1) sync_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // ideal modulator: quadrant signs chosen by the slicer rules
  function automatic void build(input logic [20:0] w,
                                input bit noisy);
    logic [21:0] bits;
    real si, sq, th;
    int  v;
    bits = {w, 1'b0};
    for (int k = 0; k < SYMS_PER_FRAME; k++) begin
      si = bits[21-2*k] ? -1.0 : 1.0;
      sq = (bits[21-2*k] ^ bits[20-2*k]) ? -1.0 : 1.0;
      for (int n = 0; n < SAMPLES_PER_SYM; n++) begin
        th = 9.0 * n * PI / 180.0;
        v  = 32768 + $rtoi(14000.0 *
             (si * $cos(th) + sq * $sin(th)));
        if (noisy)
          v += int'($urandom_range(8000)) - 4000;
        fr[k*SAMPLES_PER_SYM+n] = v;
      end
    end
  endfunction

  // floating-point correlate-and-slice reference
  function automatic logic [20:0] model();
    logic [21:0] bits;
    real ci, cq, th, xv;
    bits = '0;
    for (int k = 0; k < SYMS_PER_FRAME; k++) begin
      ci = 0.0;
      cq = 0.0;
      for (int n = 0; n < SAMPLES_PER_SYM; n++) begin
        th = 9.0 * n * PI / 180.0;
        xv = real'(fr[k*SAMPLES_PER_SYM+n] - 32768);
        ci += xv * $cos(th);
        cq += xv * $sin(th);
      end
      bits = {bits[19:0], ci < 0.0,
              (ci < 0.0) ^ (cq < 0.0)};
    end
    return bits[21:1];
  endfunction

  task automatic send(input int nsmp, input int gmax);
    int g;
    for (int i = 0; i < nsmp; i++) begin
      g = (gmax > 0) ? int'($urandom_range(gmax)) : 0;
      repeat (g) begin
        @(negedge clk);
        bif.inwrite = 1'b0;
      end
      @(negedge clk);
      bif.inwrite = 1'b1;
      bif.indata  = 16'(fr[i]);
    end
    @(negedge clk);
    bif.inwrite = 1'b0;
  endtask

  task automatic run_frame(input string name,
                           input int gmax,
                           input int hold,
                           input logic [20:0] exp,
                           output logic [20:0] got);
    int s0, t;
    s0 = sync_cnt;
    send(FR, gmax);
    check({name, "_lat1"}, 32'(bif.outvalid), 32'(0));
    @(negedge clk);
    check({name, "_lat2"}, 32'(bif.outvalid), 32'(1));
    t = 0;
    while (bif.outvalid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({name, "_data"}, 32'(bif.outdata), 32'(exp));
    got = bif.outdata;
    if (hold > 0) begin
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        check({name, "_hold"},
              32'({bif.outvalid, bif.waitwrite, bif.outdata}),
              32'({1'b1, 1'b0, exp}));
      end
      @(negedge clk);
      bif.inwrite   = 1'b1;
      bif.indata    = 16'hFFFF;
      bif.frame_end = 1'b1;
      @(negedge clk);
      bif.inwrite   = 1'b0;
      bif.frame_end = 1'b0;
      check({name, "_overrun"},
            32'({bif.outvalid, bif.waitwrite, bif.outdata}),
            32'({1'b1, 1'b0, exp}));
      s0 = s0 + 1;
    end
    @(negedge clk);
    bif.outack = 1'b1;
    @(negedge clk);
    bif.outack = 1'b0;
    check({name, "_ack"},
          32'({bif.outvalid, bif.waitwrite, bif.outdata}),
          32'({1'b0, 1'b1, exp}));
    @(negedge clk);
    check({name, "_sync"}, 32'(sync_cnt), 32'(s0));
  endtask

  initial begin
    logic [20:0] w, exp, got;
    int s0, biterr;

    vecs[0] = '{21'h000000, 0, 0,  21'h000000};
    vecs[1] = '{21'h155555, 5, 0,  21'h155555};
    vecs[2] = '{21'h1FFFFF, 5, 0,  21'h1FFFFF};
    vecs[3] = '{21'h0ABCDE, 5, 20, 21'h0ABCDE};

    bif.indata    = '0;
    bif.inwrite   = 1'b0;
    bif.frame_end = 1'b0;
    bif.outack    = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_outvalid", 32'(bif.outvalid), 32'(0));
    check("rst_sync_err", 32'(bif.sync_err), 32'(0));
    check("rst_waitwrite", 32'(bif.waitwrite), 32'(1));
    check("rst_outdata", 32'(bif.outdata), 32'(0));

    for (int i = 0; i < 4; i++) begin
      build(vecs[i].word, 1'b0);
      run_frame($sformatf("vec%0d", i), vecs[i].gmax,
                vecs[i].hold, vecs[i].exp, got);
    end

    build(21'h012345, 1'b0);
    s0 = sync_cnt;
    send(100, 1);
    @(negedge clk);
    bif.frame_end = 1'b1;
    @(negedge clk);
    bif.frame_end = 1'b0;
    repeat (3) @(negedge clk);
    check("resync_pulse", 32'(sync_cnt), 32'(s0 + 1));
    check("resync_novalid", 32'(bif.outvalid), 32'(0));
    @(negedge clk);
    bif.frame_end = 1'b1;
    @(negedge clk);
    bif.frame_end = 1'b0;
    repeat (3) @(negedge clk);
    check("fe_noop", 32'(sync_cnt), 32'(s0 + 1));
    run_frame("f12345", 2, 0, 21'h012345, got);

    build(21'($urandom), 1'b1);
    s0 = sync_cnt;
    send(150, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_sync", 32'(sync_cnt), 32'(s0));
    check("rst_mid_out",
          32'({bif.outvalid, bif.waitwrite}), 32'(1));

    biterr = 0;
    for (int f = 0; f < 20; f++) begin
      w = 21'($urandom);
      build(w, 1'b1);
      exp = model();
      run_frame($sformatf("rnd%0d", f), 2, 0, exp, got);
      biterr += $countones(got ^ w);
    end
    check("bit_errors", 32'(biterr), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
